vco_ctrl: RTL and testbench

//  Sequencer for the BTLE TX vco: loads the cos/sin lookup tables into the vco dual-port RAMs from a table ROM.

---
 rtl/btle_pkg.sv | 24 ++
 rtl/vco_table_loader.sv | 49 ++++
 rtl/vco_ctrl.sv | 149 ++++++++++++++
 tb/tb_vco_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btle_pkg.sv
// Shared definitions for the BTLE TX vco control path: sequencer state
// encoding and default widths.
package btle_pkg;
  localparam int VCO_BIT_WIDTH_DEF          = 16;
  localparam int SIN_COS_ADDR_BIT_WIDTH_DEF = 11;
  localparam int IQ_BIT_WIDTH_DEF           = 8;
  localparam int CNT_WIDTH_DEF              = 16;
  localparam int DRAIN_TIMEOUT_DEF          = 64;
  localparam int SAMPLE_PERIOD_8M           = 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_READY = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    LOAD  = ST_LOAD,
    READY = ST_READY,
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN
  } vco_state_t;
endpackage

// File: rtl/vco_table_loader.sv
// Walks the table ROM once per start pulse and replays each entry into the
// vco RAM write port one clock later, when the ROM data has arrived.
module vco_table_loader #(
  parameter int ADDR_W = 11,
  parameter int IQ_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic signed [IQ_W-1:0]   rd_cos,
  input  logic signed [IQ_W-1:0]   rd_sin,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic signed [IQ_W-1:0]   wr_cos,
  output logic signed [IQ_W-1:0]   wr_sin,
  output logic                     done
);
  localparam logic [ADDR_W-1:0] LAST = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
    end else begin
      wr_en   <= rd_en;
      wr_addr <= rd_en ? rd_addr : '0;
      if (start) begin
        rd_en   <= 1'b1;
        rd_addr <= '0;
      end else if (rd_en) begin
        if (rd_addr == LAST) begin
          rd_en   <= 1'b0;
          rd_addr <= '0;
        end else begin
          rd_addr <= rd_addr + 1'b1;
        end
      end
    end
  end

  // ROM data is only meaningful on write cycles; keep the bus quiet otherwise.
  assign wr_cos = wr_en ? rd_cos : '0;
  assign wr_sin = wr_en ? rd_sin : '0;
  assign done   = wr_en && (wr_addr == LAST);
endmodule

// File: rtl/vco_ctrl.sv
// BTLE TX vco sequencer: table load, sample pacing into the vco, and
// per-packet sample accounting with a drain timeout.
module vco_ctrl
  import btle_pkg::*;
#(
  parameter int VCO_BIT_WIDTH          = VCO_BIT_WIDTH_DEF,
  parameter int SIN_COS_ADDR_BIT_WIDTH = SIN_COS_ADDR_BIT_WIDTH_DEF,
  parameter int IQ_BIT_WIDTH           = IQ_BIT_WIDTH_DEF,
  parameter int SAMPLE_PERIOD          = SAMPLE_PERIOD_8M,
  parameter int CNT_WIDTH              = CNT_WIDTH_DEF,
  parameter int DRAIN_TIMEOUT          = DRAIN_TIMEOUT_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                init_start,
  output logic                                init_done,
  output logic                                table_rd_en,
  output logic [SIN_COS_ADDR_BIT_WIDTH-1:0]   table_rd_addr,
  input  logic signed [IQ_BIT_WIDTH-1:0]      table_rd_cos,
  input  logic signed [IQ_BIT_WIDTH-1:0]      table_rd_sin,
  output logic [SIN_COS_ADDR_BIT_WIDTH-1:0]   cos_table_write_address,
  output logic signed [IQ_BIT_WIDTH-1:0]      cos_table_write_data,
  output logic [SIN_COS_ADDR_BIT_WIDTH-1:0]   sin_table_write_address,
  output logic signed [IQ_BIT_WIDTH-1:0]      sin_table_write_data,
  output logic                                table_write_en,
  input  logic signed [VCO_BIT_WIDTH-1:0]     voltage_in,
  input  logic                                voltage_in_valid,
  input  logic                                voltage_in_last,
  output logic                                voltage_in_ready,
  output logic signed [VCO_BIT_WIDTH-1:0]     voltage_signal,
  output logic                                voltage_signal_valid,
  input  logic                                sin_cos_out_valid,
  output logic                                busy,
  output logic                                pkt_done,
  output logic                                pkt_error,
  output logic [CNT_WIDTH-1:0]                in_cnt,
  output logic [CNT_WIDTH-1:0]                out_cnt
);
  localparam int PACE_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [PACE_W-1:0] PACE_LOAD = PACE_W'(SAMPLE_PERIOD - 1);
  localparam int DR_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [DR_W-1:0] DR_LAST = DR_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  vco_state_t state, state_nxt;
  logic [PACE_W-1:0] pace_cnt;
  logic [DR_W-1:0]   drain_cnt;
  logic err_lat, load_start, load_done, accept, in_pkt;
  logic cnt_match, cnt_over, drain_timeout, finish;
  logic [SIN_COS_ADDR_BIT_WIDTH-1:0] wr_addr;

  vco_table_loader #(
    .ADDR_W (SIN_COS_ADDR_BIT_WIDTH),
    .IQ_W   (IQ_BIT_WIDTH)
  ) u_loader (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (load_start),
    .rd_en   (table_rd_en),
    .rd_addr (table_rd_addr),
    .rd_cos  (table_rd_cos),
    .rd_sin  (table_rd_sin),
    .wr_en   (table_write_en),
    .wr_addr (wr_addr),
    .wr_cos  (cos_table_write_data),
    .wr_sin  (sin_table_write_data),
    .done    (load_done)
  );

  assign cos_table_write_address = wr_addr;
  assign sin_table_write_address = wr_addr;

  assign in_pkt        = (state == RUN) || (state == DRAIN);
  assign busy          = (state == LOAD) || in_pkt;
  assign load_start    = init_start && ((state == IDLE) || (state == READY));
  // A reload request in READY wins over a sample offered in the same clock.
  assign voltage_in_ready = ((state == RUN) || ((state == READY) && !init_start)) &&
                            (pace_cnt == '0);
  assign accept        = voltage_in_valid && voltage_in_ready;
  assign cnt_match     = (out_cnt == in_cnt);
  assign cnt_over      = (out_cnt > in_cnt);
  assign drain_timeout = (drain_cnt == DR_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    unique case (state)
      IDLE:  if (load_start) state_nxt = LOAD;
      LOAD:  if (load_done)  state_nxt = READY;
      READY: begin
        if (load_start)  state_nxt = LOAD;
        else if (accept) state_nxt = voltage_in_last ? DRAIN : RUN;
      end
      RUN:   if (accept && voltage_in_last) state_nxt = DRAIN;
      DRAIN: begin
        if (cnt_match || drain_timeout) begin
          state_nxt = READY;
          finish    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done            <= 1'b0;
      pace_cnt             <= '0;
      drain_cnt            <= '0;
      voltage_signal       <= '0;
      voltage_signal_valid <= 1'b0;
      in_cnt               <= '0;
      out_cnt              <= '0;
      err_lat              <= 1'b0;
      pkt_done             <= 1'b0;
      pkt_error            <= 1'b0;
    end else begin
      if (load_start)                    init_done <= 1'b0;
      else if (state == LOAD && load_done) init_done <= 1'b1;

      if (accept)              pace_cnt <= PACE_LOAD;
      else if (pace_cnt != '0) pace_cnt <= pace_cnt - 1'b1;

      voltage_signal_valid <= accept;
      if (accept) voltage_signal <= voltage_in;

      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;

      // First sample of a packet restarts the accounting.
      if (state == READY && accept) begin
        in_cnt  <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        out_cnt <= '0;
        err_lat <= 1'b0;
      end else if (in_pkt) begin
        if (accept && in_cnt != CNT_MAX)             in_cnt  <= in_cnt + 1'b1;
        if (sin_cos_out_valid && out_cnt != CNT_MAX) out_cnt <= out_cnt + 1'b1;
        if (cnt_over)                                err_lat <= 1'b1;
      end

      pkt_done  <= finish;
      pkt_error <= finish && (!cnt_match || err_lat);
    end
  end
endmodule

// File: tb/tb_vco_ctrl.sv
// Bench for vco_ctrl: cycle-level behavioural model checked every clock,
// ROM and vco stand-ins, directed scenarios plus randomized packets.
module tb_vco_ctrl;
  localparam int VW = 16, AW = 11, IW = 8, SP = 2, CW = 16, TO = 64;
  localparam int DEPTH = 1 << AW;
  localparam int CMAX = (1 << CW) - 1;

  logic clk, rst_n, init_start, init_done, table_rd_en, table_write_en;
  logic [AW-1:0] table_rd_addr, cos_wa, sin_wa;
  logic signed [IW-1:0] table_rd_cos, table_rd_sin, cos_wd, sin_wd;
  logic signed [VW-1:0] voltage_in, voltage_signal;
  logic voltage_in_valid, voltage_in_last, voltage_in_ready, voltage_signal_valid;
  logic sin_cos_out_valid, busy, pkt_done, pkt_error;
  logic [CW-1:0] in_cnt, out_cnt;

  vco_ctrl #(.VCO_BIT_WIDTH(VW), .SIN_COS_ADDR_BIT_WIDTH(AW), .IQ_BIT_WIDTH(IW),
             .SAMPLE_PERIOD(SP), .CNT_WIDTH(CW), .DRAIN_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .init_start(init_start), .init_done(init_done),
    .table_rd_en(table_rd_en), .table_rd_addr(table_rd_addr),
    .table_rd_cos(table_rd_cos), .table_rd_sin(table_rd_sin),
    .cos_table_write_address(cos_wa), .cos_table_write_data(cos_wd),
    .sin_table_write_address(sin_wa), .sin_table_write_data(sin_wd),
    .table_write_en(table_write_en), .voltage_in(voltage_in),
    .voltage_in_valid(voltage_in_valid), .voltage_in_last(voltage_in_last),
    .voltage_in_ready(voltage_in_ready), .voltage_signal(voltage_signal),
    .voltage_signal_valid(voltage_signal_valid), .sin_cos_out_valid(sin_cos_out_valid),
    .busy(busy), .pkt_done(pkt_done), .pkt_error(pkt_error),
    .in_cnt(in_cnt), .out_cnt(out_cnt));

  int checks = 0, failures = 0, cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic signed [IW-1:0] rom_cos(input int a);
    return IW'(a * 37 + 5);
  endfunction
  function automatic logic signed [IW-1:0] rom_sin(input int a);
    return IW'(a ^ (a >> 3) ^ 8'h5A);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model, evaluated once per clock ----------------
  typedef enum {M_IDLE, M_LOAD, M_READY, M_RUN, M_DRAIN} mmode_t;
  mmode_t m_mode;
  int mc = 0, m_lstart, m_dstart, m_last_acc, m_in, m_out;
  bit m_loaded, m_err, m_done, m_perr, m_pacc;
  logic signed [VW-1:0] m_pdata;

  always @(negedge clk) begin
    int off;
    bit e_ready, acc;
    mc++;
    if (!rst_n) begin
      m_mode = M_IDLE; m_loaded = 0; m_in = 0; m_out = 0; m_err = 0;
      m_done = 0; m_perr = 0; m_pacc = 0; m_pdata = '0;
      m_last_acc = -1000; m_lstart = 0; m_dstart = 0;
    end
    off = mc - m_lstart;
    e_ready = ((m_mode == M_READY && !init_start) || m_mode == M_RUN) &&
              (mc - m_last_acc >= SP);
    chk("init_done", init_done, m_loaded);
    chk("busy", busy, m_mode inside {M_LOAD, M_RUN, M_DRAIN});
    chk("ready", voltage_in_ready, e_ready);
    chk("rd_en", table_rd_en, m_mode == M_LOAD && off < DEPTH);
    if (table_rd_en) chk("rd_addr", table_rd_addr, off);
    chk("wr_en", table_write_en, m_mode == M_LOAD && off >= 1);
    if (table_write_en) begin
      chk("cos_waddr", cos_wa, off - 1);
      chk("sin_waddr", sin_wa, off - 1);
      chk("cos_wdata", cos_wd, rom_cos(off - 1));
      chk("sin_wdata", sin_wd, rom_sin(off - 1));
    end
    chk("vsig_valid", voltage_signal_valid, m_pacc);
    if (m_pacc) chk("vsig_data", voltage_signal, m_pdata);
    chk("in_cnt", in_cnt, m_in);
    chk("out_cnt", out_cnt, m_out);
    chk("pkt_done", pkt_done, m_done);
    chk("pkt_error", pkt_error, m_perr);
    if (rst_n) begin
      acc = voltage_in_valid && e_ready;
      m_done = 0; m_perr = 0;
      if ((m_mode == M_RUN || m_mode == M_DRAIN) && m_out > m_in) m_err = 1;
      case (m_mode)
        M_IDLE: if (init_start) begin m_mode = M_LOAD; m_lstart = mc + 1; end
        M_LOAD: if (off == DEPTH) begin m_mode = M_READY; m_loaded = 1; end
        M_READY: begin
          if (init_start) begin
            m_mode = M_LOAD; m_lstart = mc + 1; m_loaded = 0;
          end else if (acc) begin
            m_in = 1; m_out = 0; m_err = 0;
            if (voltage_in_last) begin m_mode = M_DRAIN; m_dstart = mc + 1; end
            else m_mode = M_RUN;
          end
        end
        M_RUN: begin
          if (acc) begin
            if (m_in < CMAX) m_in++;
            if (voltage_in_last) begin m_mode = M_DRAIN; m_dstart = mc + 1; end
          end
          if (sin_cos_out_valid && m_out < CMAX) m_out++;
        end
        M_DRAIN: begin
          if (m_in == m_out) begin
            m_done = 1; m_perr = m_err; m_mode = M_READY;
          end else if (mc - m_dstart == TO - 1) begin
            m_done = 1; m_perr = 1; m_mode = M_READY;
          end
          if (sin_cos_out_valid && m_out < CMAX) m_out++;
        end
        default: ;
      endcase
      m_pacc = acc;
      if (acc) begin m_pdata = voltage_in; m_last_acc = mc; end
    end
  end

  // ---------------- stimulus, ROM and vco stand-ins ----------------
  bit mute, gap_chk, last_hs, rom_req, done_seen, done_err;
  logic [7:0] vpipe;
  logic [AW-1:0] rom_a;
  int n_acc, n_vsv, n_wr, n_rd, n_busy, bad_gap, prev_acc, last_acc_cyc;
  int done_cyc, done_in, done_out, last_wa;
  logic signed [IW-1:0] last_wc, last_ws;

  task automatic tick();
    bit hs;
    @(negedge clk);
    hs = voltage_in_valid && voltage_in_ready;
    if (hs) begin
      n_acc++;
      if (gap_chk && prev_acc >= 0 && cyc - prev_acc != SP) bad_gap++;
      prev_acc = cyc;
      if (voltage_in_last) last_acc_cyc = cyc;
    end
    if (voltage_signal_valid) n_vsv++;
    if (table_write_en) begin n_wr++; last_wa = int'(cos_wa); last_wc = cos_wd; last_ws = sin_wd; end
    if (table_rd_en) n_rd++;
    if (busy) n_busy++;
    if (pkt_done && !done_seen) begin
      done_seen = 1; done_cyc = cyc; done_in = int'(in_cnt);
      done_out = int'(out_cnt); done_err = pkt_error;
    end
    rom_req = table_rd_en; rom_a = table_rd_addr;
    @(posedge clk); #1;
    if (rom_req) begin table_rd_cos = rom_cos(int'(rom_a)); table_rd_sin = rom_sin(int'(rom_a)); end
    vpipe = {vpipe[6:0], voltage_signal_valid && !mute};
    sin_cos_out_valid = vpipe[2];
    init_start = 1'b0;
    if (hs) voltage_in_valid = 1'b0;
    last_hs = hs;
  endtask

  task automatic do_load();
    n_wr = 0; n_rd = 0; n_busy = 0;
    init_start = 1'b1;
    for (int w = 0; w < 2200; w++) begin
      tick();
      if (init_done) break;
    end
    chk("load_init_done", init_done, 1);
    chk("load_busy_clks", n_busy, DEPTH + 1);
    chk("load_writes", n_wr, DEPTH);
    chk("load_reads", n_rd, DEPTH);
    chk("load_last_addr", last_wa, DEPTH - 1);
    chk("load_last_cos", last_wc, rom_cos(DEPTH - 1));
    chk("load_last_sin", last_ws, rom_sin(DEPTH - 1));
  endtask

  task automatic async_reset();
    @(posedge clk); #3;
    rst_n = 1'b0; voltage_in_valid = 1'b0; voltage_in_last = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_init_done", init_done, 0);
    chk("arst_vsig_valid", voltage_signal_valid, 0);
    chk("arst_in_cnt", in_cnt, 0);
    chk("arst_all_zero", |{init_done, table_rd_en, table_rd_addr, cos_wa, cos_wd, sin_wa,
        sin_wd, table_write_en, voltage_in_ready, voltage_signal, voltage_signal_valid,
        busy, pkt_done, pkt_error, in_cnt, out_cnt}, 0);
    vpipe = '0; sin_cos_out_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic send_pkt(input int len, input bit hold, input int poke_at, input int abort_at);
    done_seen = 0; prev_acc = -1; gap_chk = hold;
    for (int i = 0; i < len; i++) begin
      if (i == abort_at) begin async_reset(); return; end
      if (!hold) repeat ($urandom_range(0, 2)) tick();
      voltage_in = VW'($urandom);
      voltage_in_last = (i == len - 1);
      voltage_in_valid = 1'b1;
      if (i == poke_at) init_start = 1'b1;
      for (int w = 0; ; w++) begin
        tick();
        if (last_hs) break;
        if (w == 50) begin
          chk("accept_timeout", 0, 1);
          voltage_in_valid = 1'b0;
          return;
        end
      end
    end
    voltage_in_last = 1'b0;
    for (int w = 0; w < 300 && !done_seen; w++) tick();
    chk("pkt_done_seen", done_seen, 1);
  endtask

  initial begin
    rst_n = 1'b0; init_start = 1'b0; table_rd_cos = '0; table_rd_sin = '0;
    voltage_in = '0; voltage_in_valid = 1'b0; voltage_in_last = 1'b0;
    sin_cos_out_valid = 1'b0; vpipe = '0; mute = 0; gap_chk = 0; bad_gap = 0;
    n_acc = 0; n_vsv = 0; prev_acc = -1; last_acc_cyc = 0;
    repeat (3) tick();
    chk("reset_busy", busy, 0);
    chk("reset_init_done", init_done, 0);
    chk("reset_ready", voltage_in_ready, 0);
    rst_n = 1'b1;

    // offered before any table load: must be held off
    n_acc = 0; n_vsv = 0; voltage_in = 16'sh1234; voltage_in_valid = 1'b1;
    repeat (8) tick();
    chk("preload_accepts", n_acc, 0);
    chk("preload_forwarded", n_vsv, 0);
    voltage_in_valid = 1'b0;

    do_load();

    // 100 back-to-back samples, reload request poked mid-packet
    n_acc = 0; n_vsv = 0; n_rd = 0; bad_gap = 0;
    send_pkt(100, 1, 3, -1);
    chk("p100_accepts", n_acc, 100);
    chk("p100_spacing_errs", bad_gap, 0);
    chk("p100_forwarded", n_vsv, 100);
    chk("p100_in_cnt", done_in, 100);
    chk("p100_out_cnt", done_out, 100);
    chk("p100_error", done_err, 0);
    chk("p100_no_reload", n_rd, 0);

    // vco silent: timeout 64 clks after drain entry (= last accept + 1)
    mute = 1;
    send_pkt(20, 1, -1, -1);
    chk("mute_timeout_clks", done_cyc - (last_acc_cyc + 1), TO);
    chk("mute_error", done_err, 1);
    chk("mute_in_cnt", done_in, 20);
    chk("mute_out_cnt", done_out, 0);
    mute = 0;

    send_pkt(1, 0, -1, -1);
    chk("single_in_cnt", done_in, 1);
    chk("single_out_cnt", done_out, 1);
    chk("single_error", done_err, 0);

    repeat (15) begin
      int len;
      len = $urandom_range(1, 12);
      mute = ($urandom_range(0, 4) == 0);
      send_pkt(len, 0, -1, -1);
      chk("rnd_in_cnt", done_in, len);
      chk("rnd_error", done_err, mute);
      mute = 0;
    end

    // reset mid-RUN: tables lost, samples refused until reload
    send_pkt(30, 1, -1, 10);
    n_acc = 0; voltage_in = 16'sh0F0F; voltage_in_valid = 1'b1;
    repeat (8) tick();
    chk("post_rst_accepts", n_acc, 0);
    chk("post_rst_init_done", init_done, 0);
    voltage_in_valid = 1'b0;

    do_load();
    send_pkt(5, 1, -1, -1);
    chk("reload_in_cnt", done_in, 5);
    chk("reload_out_cnt", done_out, 5);
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
